mem_write_checker: RTL and testbench

- Synthesizable, parametrised bus monitor on the SoC data-memory write port (Address / Write_Data / Mem_Write).
- Replaces the single hard-coded "address 100 = 7" pass check with an ordered table of up to Depth expected writes.
- Adds a watch window, a cycle-timeout watchdog and a latched pass/fail result with diagnostics.
- Instantiated in SoC benches and usable on FPGA for board self-test.

---
 rtl/mem_write_checker_if.sv | 43 ++++
 rtl/mem_write_checker.sv | 195 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
// Bus bundle for mem_write_checker: table load port, run control, monitored
// write port and the latched result/diagnostic outputs.
interface mem_write_checker_if #(
  parameter int BusWidth = 32,
  parameter int Depth    = 8
);
  localparam int IdxW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic                i_Load_En;
  logic [IdxW-1:0]     i_Load_Index;
  logic [BusWidth-1:0] i_Load_Address;
  logic [BusWidth-1:0] i_Load_Data;
  logic [CntW-1:0]     i_Expected_Count;
  logic                i_Start;
  logic                i_Mem_Write;
  logic [BusWidth-1:0] i_Address;
  logic [BusWidth-1:0] i_Write_Data;

  logic                o_Busy;
  logic                o_Done;
  logic                o_Pass;
  logic [1:0]          o_Fail_Code;
  logic [IdxW-1:0]     o_Fail_Index;
  logic [BusWidth-1:0] o_Fail_Address;
  logic [BusWidth-1:0] o_Fail_Data;
  logic [15:0]         o_Write_Count;
  logic [7:0]          o_Error_Count;

  modport slave (
    input  i_Load_En, i_Load_Index, i_Load_Address, i_Load_Data,
    input  i_Expected_Count, i_Start, i_Mem_Write, i_Address, i_Write_Data,
    output o_Busy, o_Done, o_Pass, o_Fail_Code, o_Fail_Index,
    output o_Fail_Address, o_Fail_Data, o_Write_Count, o_Error_Count
  );

  modport master (
    output i_Load_En, i_Load_Index, i_Load_Address, i_Load_Data,
    output i_Expected_Count, i_Start, i_Mem_Write, i_Address, i_Write_Data,
    input  o_Busy, o_Done, o_Pass, o_Fail_Code, o_Fail_Index,
    input  o_Fail_Address, o_Fail_Data, o_Write_Count, o_Error_Count
  );
endinterface

// File: rtl/mem_write_checker.sv
// Data-memory write-port monitor: checks watched writes against an ordered table.
// Optional MEM_CHECK_CONTINUE_EN keeps checking after a mismatch until the last entry.
module mem_write_checker #(
  parameter int          BusWidth      = 32,
  parameter int          Depth         = 8,
  parameter int unsigned WatchBase     = 0,
  parameter int unsigned WatchSize     = 256,
  parameter int unsigned TimeoutCycles = 4096
) (
  input logic              CLK,
  input logic              RESET,
  mem_write_checker_if.slave bus
);
  localparam int IdxW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  localparam logic [BusWidth:0]   WIN_LO     = (BusWidth+1)'(WatchBase);
  localparam logic [BusWidth:0]   WIN_HI     = WIN_LO + (BusWidth+1)'(WatchSize);
  localparam logic [31:0]         TIMER_LAST = 32'(TimeoutCycles - 32'd1);
  localparam logic [CntW-1:0]     DEPTH_C    = CntW'(Depth);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ADDR    = 2'd1;
  localparam logic [1:0] CODE_DATA    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t              state_r, state_next;
  logic [CntW-1:0]     index_r, index_next;
  logic [CntW-1:0]     count_r, count_next;
  logic [31:0]         timer_r, timer_next;
  logic [15:0]         wcount_r, wcount_next;
  logic [7:0]          ecount_r, ecount_next;
  logic [1:0]          fcode_r, fcode_next;
  logic [IdxW-1:0]     findex_r, findex_next;
  logic [BusWidth-1:0] faddr_r, faddr_next;
  logic [BusWidth-1:0] fdata_r, fdata_next;
  logic                busy_r, done_r, pass_r;

  logic [BusWidth-1:0] exp_addr_r [Depth];
  logic [BusWidth-1:0] exp_data_r [Depth];

  logic [CntW-1:0]     exp_cnt_s;
  logic                in_window_s, hit_s, addr_ok_s, data_ok_s, last_s, timeout_s;

  assign exp_cnt_s   = (bus.i_Expected_Count > DEPTH_C) ? DEPTH_C : bus.i_Expected_Count;
  assign in_window_s = ({1'b0, bus.i_Address} >= WIN_LO) && ({1'b0, bus.i_Address} < WIN_HI);
  assign hit_s       = (state_r == S_RUN) && bus.i_Mem_Write && in_window_s;
  assign addr_ok_s   = (bus.i_Address == exp_addr_r[index_r[IdxW-1:0]]);
  assign data_ok_s   = (bus.i_Write_Data == exp_data_r[index_r[IdxW-1:0]]);
  assign last_s      = ((index_r + CntW'(1)) == count_r);
  assign timeout_s   = (TimeoutCycles != 32'd0) && (timer_r == TIMER_LAST);

  // Table load; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (!RESET && (state_r == S_IDLE) && bus.i_Load_En && (int'(bus.i_Load_Index) < Depth)) begin
      exp_addr_r[bus.i_Load_Index] <= bus.i_Load_Address;
      exp_data_r[bus.i_Load_Index] <= bus.i_Load_Data;
    end
  end

  // Next-state and run bookkeeping.
  always_comb begin
    state_next  = state_r;
    index_next  = index_r;
    count_next  = count_r;
    timer_next  = timer_r;
    wcount_next = wcount_r;
    ecount_next = ecount_r;
    fcode_next  = fcode_r;
    findex_next = findex_r;
    faddr_next  = faddr_r;
    fdata_next  = fdata_r;
    case (state_r)
      S_IDLE, S_PASS, S_FAIL: begin
        if (bus.i_Start) begin
          index_next  = '0;
          count_next  = exp_cnt_s;
          timer_next  = 32'd0;
          wcount_next = 16'd0;
          ecount_next = 8'd0;
          fcode_next  = CODE_NONE;
          findex_next = '0;
          faddr_next  = '0;
          fdata_next  = '0;
          state_next  = (exp_cnt_s == '0) ? S_PASS : S_RUN;
        end else begin
          state_next = state_r;
        end
      end
      S_RUN: begin
        timer_next = timer_r + 32'd1;
        if (hit_s) begin
          wcount_next = (wcount_r == 16'hFFFF) ? wcount_r : wcount_r + 16'd1;
          if (addr_ok_s && data_ok_s) begin
            index_next = index_r + CntW'(1);
            if (last_s) begin
              state_next = (ecount_r == 8'd0) ? S_PASS : S_FAIL;
            end else begin
              state_next = S_RUN;
            end
          end else begin
            ecount_next = (ecount_r == 8'hFF) ? ecount_r : ecount_r + 8'd1;
            if (fcode_r == CODE_NONE) begin
              fcode_next  = addr_ok_s ? CODE_DATA : CODE_ADDR;
              findex_next = index_r[IdxW-1:0];
              faddr_next  = bus.i_Address;
              fdata_next  = bus.i_Write_Data;
            end else begin
              fcode_next = fcode_r;
            end
`ifdef MEM_CHECK_CONTINUE_EN
            index_next = index_r + CntW'(1);
            if (last_s) begin
              state_next = S_FAIL;
            end else begin
              state_next = S_RUN;
            end
`else
            state_next = S_FAIL;
`endif
          end
        end else begin
          wcount_next = wcount_r;
        end
        // A write on the deadline cycle is judged first; timeout only if still running.
        if (timeout_s && (state_next == S_RUN)) begin
          state_next = S_FAIL;
          if (fcode_next == CODE_NONE) begin
            fcode_next  = CODE_TIMEOUT;
            findex_next = index_next[IdxW-1:0];
            faddr_next  = '0;
            fdata_next  = '0;
          end else begin
            fcode_next = fcode_next;
          end
        end else begin
          timer_next = timer_r + 32'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= S_IDLE;
      index_r  <= '0;
      count_r  <= '0;
      timer_r  <= 32'd0;
      wcount_r <= 16'd0;
      ecount_r <= 8'd0;
      fcode_r  <= CODE_NONE;
      findex_r <= '0;
      faddr_r  <= '0;
      fdata_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_next;
      index_r  <= index_next;
      count_r  <= count_next;
      timer_r  <= timer_next;
      wcount_r <= wcount_next;
      ecount_r <= ecount_next;
      fcode_r  <= fcode_next;
      findex_r <= findex_next;
      faddr_r  <= faddr_next;
      fdata_r  <= fdata_next;
      busy_r   <= (state_next == S_RUN);
      done_r   <= (state_next == S_PASS) || (state_next == S_FAIL);
      pass_r   <= (state_next == S_PASS);
    end
  end

  assign bus.o_Busy         = busy_r;
  assign bus.o_Done         = done_r;
  assign bus.o_Pass         = pass_r;
  assign bus.o_Fail_Code    = fcode_r;
  assign bus.o_Fail_Index   = findex_r;
  assign bus.o_Fail_Address = faddr_r;
  assign bus.o_Fail_Data    = fdata_r;
  assign bus.o_Write_Count  = wcount_r;
  assign bus.o_Error_Count  = ecount_r;
endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized and directed bench for mem_write_checker against a run-level reference model.
module tb_mem_write_checker;
  localparam int BW = 32;
  localparam int DP = 8;
  localparam int WB = 0;
  localparam int WS = 256;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_write_checker_if #(.BusWidth(BW), .Depth(DP)) bus();

  mem_write_checker #(
    .BusWidth(BW), .Depth(DP), .WatchBase(WB), .WatchSize(WS), .TimeoutCycles(TO)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] tbl_addr [DP];
  logic [31:0] tbl_data [DP];
  logic        st_en   [40];
  logic [31:0] st_addr [40];
  logic [31:0] st_data [40];
  int          st_len;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_Load_En        = 1'b0;
    bus.i_Load_Index     = 3'd0;
    bus.i_Load_Address   = 32'd0;
    bus.i_Load_Data      = 32'd0;
    bus.i_Expected_Count = 4'd0;
    bus.i_Start          = 1'b0;
    bus.i_Mem_Write      = 1'b0;
    bus.i_Address        = 32'd0;
    bus.i_Write_Data     = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_table(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_Load_En      = 1'b1;
      bus.i_Load_Index   = 3'(i);
      bus.i_Load_Address = tbl_addr[i];
      bus.i_Load_Data    = tbl_data[i];
      @(negedge clk);
    end
    bus.i_Load_En = 1'b0;
  endtask

  task automatic set_st(input int i, input logic en, input logic [31:0] a, input logic [31:0] d);
    st_en[i]   = en;
    st_addr[i] = a;
    st_data[i] = d;
  endtask

  function automatic bit watched(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(WB)) && (la < longint'(WB) + longint'(WS));
  endfunction

  // Starts a run with raw count cnt, plays the stimulus list and checks the result.
  task automatic run_case(input string name, input int cnt);
    int eff, idx, e_done, e_pass, e_code, e_fidx, e_wc, e_ec, got_done;
    logic [31:0] e_faddr, e_fdata;
    eff = (cnt > DP) ? DP : cnt;
    idx = 0; e_done = -1; e_pass = 0; e_code = 0; e_fidx = 0; e_wc = 0; e_ec = 0;
    e_faddr = 32'd0; e_fdata = 32'd0;
    if (eff == 0) begin
      e_done = 0;
      e_pass = 1;
    end
    for (int c = 1; c <= TO && e_done < 0; c++) begin
      int i;
      i = c - 1;
      if (i < st_len && st_en[i] && watched(st_addr[i])) begin
        e_wc++;
        if (st_addr[i] == tbl_addr[idx] && st_data[i] == tbl_data[idx]) begin
          idx++;
          if (idx == eff) begin
            e_done = c;
            e_pass = (e_ec == 0) ? 1 : 0;
          end
        end else begin
          e_ec++;
          if (e_code == 0) begin
            e_code  = (st_addr[i] != tbl_addr[idx]) ? 1 : 2;
            e_fidx  = idx;
            e_faddr = st_addr[i];
            e_fdata = st_data[i];
          end
`ifdef MEM_CHECK_CONTINUE_EN
          idx++;
          if (idx == eff) e_done = c;
`else
          e_done = c;
`endif
        end
      end
      if (e_done < 0 && c == TO) begin
        e_done = c;
        if (e_code == 0) begin
          e_code  = 3;
          e_fidx  = idx;
          e_faddr = 32'd0;
          e_fdata = 32'd0;
        end
      end
    end

    @(negedge clk);
    bus.i_Expected_Count = 4'(cnt);
    bus.i_Start          = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    got_done = bus.o_Done ? 0 : -1;
    for (int k = 1; k <= TO + 3 && got_done < 0; k++) begin
      int i;
      i = k - 1;
      if (i < st_len) begin
        bus.i_Mem_Write  = st_en[i];
        bus.i_Address    = st_addr[i];
        bus.i_Write_Data = st_data[i];
      end else begin
        bus.i_Mem_Write  = 1'b0;
        bus.i_Address    = 32'd0;
        bus.i_Write_Data = 32'd0;
      end
      @(negedge clk);
      if (k == 1 && e_done > 1) check_val({name, ".busy_mid"}, 32'(bus.o_Busy), 32'd1);
      if (bus.o_Done) got_done = k;
    end
    idle_inputs();
    check_val({name, ".done_cycle"}, 32'(got_done), 32'(e_done));
    check_val({name, ".pass"}, 32'(bus.o_Pass), 32'(e_pass));
    check_val({name, ".busy"}, 32'(bus.o_Busy), 32'd0);
    check_val({name, ".fail_code"}, 32'(bus.o_Fail_Code), 32'(e_code));
    check_val({name, ".fail_index"}, 32'(bus.o_Fail_Index), 32'(e_fidx));
    check_val({name, ".fail_addr"}, bus.o_Fail_Address, e_faddr);
    check_val({name, ".fail_data"}, bus.o_Fail_Data, e_fdata);
    check_val({name, ".write_count"}, 32'(bus.o_Write_Count), 32'(e_wc));
    check_val({name, ".error_count"}, 32'(bus.o_Error_Count), 32'(e_ec));
  endtask

  // Random table of word-aligned in-window addresses.
  task automatic random_table();
    for (int i = 0; i < DP; i++) begin
      tbl_addr[i] = 32'($urandom_range(0, 63)) << 2;
      tbl_data[i] = $urandom;
    end
  endtask

  // Mostly-correct write stream with idles, out-of-window writes and corruptions.
  task automatic random_stim();
    int ptr, r;
    ptr = 0;
    st_len = $urandom_range(5, 24);
    for (int i = 0; i < st_len; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        set_st(i, 1'b0, $urandom, $urandom);
      end else if (r < 50) begin
        set_st(i, 1'b1, 32'd256 + ($urandom & 32'hFFFF), tbl_data[ptr]);
      end else if (r < 90) begin
        set_st(i, 1'b1, tbl_addr[ptr], tbl_data[ptr]);
        ptr = (ptr + 1) % DP;
      end else if (r < 95) begin
        set_st(i, 1'b1, tbl_addr[ptr] ^ 32'd4, tbl_data[ptr]);
        ptr = (ptr + 1) % DP;
      end else begin
        set_st(i, 1'b1, tbl_addr[ptr], tbl_data[ptr] ^ (32'd1 << $urandom_range(0, 31)));
        ptr = (ptr + 1) % DP;
      end
    end
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check_val("reset.busy", 32'(bus.o_Busy), 32'd0);
    check_val("reset.done", 32'(bus.o_Done), 32'd0);
    check_val("reset.pass", 32'(bus.o_Pass), 32'd0);
    check_val("reset.fail_code", 32'(bus.o_Fail_Code), 32'd0);
    check_val("reset.write_count", 32'(bus.o_Write_Count), 32'd0);
    check_val("reset.error_count", 32'(bus.o_Error_Count), 32'd0);

    tbl_addr[0] = 32'd100; tbl_data[0] = 32'd7;
    tbl_addr[1] = 32'd104; tbl_data[1] = 32'd9;
    load_table(2);
    st_len = 2;
    set_st(0, 1'b1, 32'd512, 32'd3);
    set_st(1, 1'b1, 32'd100, 32'd7);
    run_case("outside_then_match", 1);

    do_reset(); load_table(2);
    set_st(0, 1'b1, 32'd100, 32'd7);
    set_st(1, 1'b1, 32'd104, 32'd8);
    run_case("data_mismatch", 2);

    do_reset(); load_table(2);
    set_st(0, 1'b1, 32'd512, 32'd7);
    set_st(1, 1'b1, 32'd96, 32'd7);
    run_case("addr_mismatch", 1);

    do_reset(); load_table(2);
    st_len = 0;
    run_case("timeout", 1);

    do_reset(); load_table(2);
    st_len = 20;
    for (int i = 0; i < 19; i++) set_st(i, 1'b0, 32'd0, 32'd0);
    set_st(19, 1'b1, 32'd100, 32'd7);
    run_case("match_on_deadline", 1);

    do_reset();
    st_len = 0;
    run_case("count_zero", 0);

    // Abort after one of two matches, then rerun with the retained table.
    do_reset(); load_table(2);
    @(negedge clk);
    bus.i_Expected_Count = 4'd2;
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    bus.i_Mem_Write = 1'b1; bus.i_Address = 32'd100; bus.i_Write_Data = 32'd7;
    @(negedge clk);
    bus.i_Mem_Write = 1'b0;
    check_val("midrun.write_count", 32'(bus.o_Write_Count), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrun.reset_busy", 32'(bus.o_Busy), 32'd0);
    check_val("midrun.reset_wcount", 32'(bus.o_Write_Count), 32'd0);
    st_len = 2;
    set_st(0, 1'b1, 32'd100, 32'd7);
    set_st(1, 1'b1, 32'd104, 32'd9);
    run_case("rerun_after_reset", 2);

    do_reset(); random_table(); load_table(DP);
    st_len = DP;
    for (int i = 0; i < DP; i++) set_st(i, 1'b1, tbl_addr[i], tbl_data[i]);
    run_case("count_clamped", 15);

    for (int n = 0; n < 40; n++) begin
      if (n % 3 != 2) begin
        do_reset(); random_table(); load_table(DP);
      end
      random_stim();
      run_case($sformatf("rand%0d", n), $urandom_range(0, 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
